// File: rtl/sram_bist_pkg.sv
// Shared definitions for the single-port SRAM with March C- self-test:
// sequencer state codes, op type, march direction and background patterns.
package sram_bist_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_M0    = 3'd1;
  localparam logic [2:0] S_M1    = 3'd2;
  localparam logic [2:0] S_M2    = 3'd3;
  localparam logic [2:0] S_M3    = 3'd4;
  localparam logic [2:0] S_M4    = 3'd5;
  localparam logic [2:0] S_M5    = 3'd6;
  localparam logic [2:0] S_DRAIN = 3'd7;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

  // M3 and M4 walk the array from the top address down
  function automatic logic dir_down(input logic [2:0] st);
    return (st == S_M3) || (st == S_M4);
  endfunction

  // Background phase (0 = D0, 1 = D1) used by the read or write half of an element
  function automatic logic bg_phase(input logic [2:0] st, input op_e op);
    if (op == OP_RD) return (st == S_M2) || (st == S_M4);
    return (st == S_M1) || (st == S_M3);
  endfunction

  // One bit of the background word; checkerboard D0 has ones on even bit positions
  function automatic logic bg(input logic checkerboard, input logic phase,
                              input int unsigned bit_idx);
    return (checkerboard & ~bit_idx[0]) ^ phase;
  endfunction

endpackage

// File: rtl/sram_1p_march_bist_if.sv
// Functional port plus BIST start/status bundle for sram_1p_march_bist.
interface sram_1p_march_bist_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  A_MEN;
  logic                  A_WEN;
  logic                  A_REN;
  logic [ADDR_WIDTH-1:0] A_ADDR;
  logic [DATA_WIDTH-1:0] A_DIN;
  logic [DATA_WIDTH-1:0] A_BM;
  logic [DATA_WIDTH-1:0] A_DOUT;
  logic                  A_BIST_START;
  logic                  A_BIST_BUSY;
  logic                  A_BIST_DONE;
  logic                  A_BIST_FAIL;
  logic [ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR;
  logic [CNT_WIDTH-1:0]  A_BIST_FAIL_CNT;

  modport master (
    output A_MEN, A_WEN, A_REN, A_ADDR, A_DIN, A_BM, A_BIST_START,
    input  A_DOUT, A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_ADDR, A_BIST_FAIL_CNT
  );

  modport slave (
    input  A_MEN, A_WEN, A_REN, A_ADDR, A_DIN, A_BM, A_BIST_START,
    output A_DOUT, A_BIST_BUSY, A_BIST_DONE, A_BIST_FAIL, A_BIST_FAIL_ADDR, A_BIST_FAIL_CNT
  );
endinterface

// File: rtl/sram_1p_bm_array.sv
// Single-port storage with per-bit write mask and registered read data.
module sram_1p_bm_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] bm,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] merged;

  assign merged = (din & bm) | (mem[addr] & ~bm);

  // Masked write; contents are never reset
  always_ff @(posedge clk) begin
    if (en && wen) mem[addr] <= merged;
  end

  // Read register; a simultaneous write returns the merged word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dout <= '0;
    else if (en && ren)  dout <= wen ? merged : mem[addr];
  end
endmodule

// File: rtl/sram_1p_march_bist.sv
// Single-port SRAM with an on-chip March C- engine that owns the array while busy.
module sram_1p_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter bit          BG_CHECKER = 1'b0
) (
  input logic                 A_CLK,
  input logic                 A_RESET_N,
  sram_1p_march_bist_if.slave bus
);
  logic [2:0]            state;
  logic [2:0]            next_elem;
  op_e                   op;
  logic [ADDR_WIDTH-1:0] baddr;
  logic                  busy, run, accept, last_addr;
  logic [DATA_WIDTH-1:0] pat;

  logic                  done_q, fail_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] faddr_q;

  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [ADDR_WIDTH-1:0] exp_addr;

  logic                  a_en, a_wen, a_ren;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din, a_bm, a_dout;

  assign busy      = (state != S_IDLE);
  assign run       = busy && (state != S_DRAIN);
  assign accept    = (state == S_IDLE) && bus.A_BIST_START;
  assign next_elem = state + 3'd1;
  assign last_addr = dir_down(state) ? (baddr == '0) : (baddr == '1);

  // Background word for the current op (write data or expected read data)
  always_comb begin
    pat = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      pat[i] = bg(BG_CHECKER, bg_phase(state, op), i);
  end

  // Array port mux: BIST while running, nothing in DRAIN, else functional (START wins)
  always_comb begin
    a_en   = 1'b0;
    a_wen  = 1'b0;
    a_ren  = 1'b0;
    a_addr = '0;
    a_din  = '0;
    a_bm   = '1;
    if (run) begin
      a_en   = 1'b1;
      a_wen  = (op == OP_WR);
      a_ren  = (op == OP_RD);
      a_addr = baddr;
      a_din  = pat;
    end else if (!busy) begin
      a_en   = bus.A_MEN && !accept;
      a_wen  = bus.A_WEN;
      a_ren  = bus.A_REN;
      a_addr = bus.A_ADDR;
      a_din  = bus.A_DIN;
      a_bm   = bus.A_BM;
    end
  end

  sram_1p_bm_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (A_CLK),
    .rst_n(A_RESET_N),
    .en   (a_en),
    .wen  (a_wen),
    .ren  (a_ren),
    .addr (a_addr),
    .din  (a_din),
    .bm   (a_bm),
    .dout (a_dout)
  );

  // March sequencer: read/write pairs per address, element change at address wrap
  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      state  <= S_IDLE;
      op     <= OP_WR;
      baddr  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.A_BIST_START) begin
            state  <= S_M0;
            op     <= OP_WR;
            baddr  <= '0;
            done_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        default: begin
          if (op == OP_RD && state != S_M5) begin
            op <= OP_WR;
          end else if (last_addr) begin
            op <= OP_RD;
            if (state == S_M5) begin
              state <= S_DRAIN;
            end else begin
              state <= next_elem;
              baddr <= dir_down(next_elem) ? '1 : '0;
            end
          end else begin
            op    <= (state == S_M0) ? OP_WR : OP_RD;
            baddr <= dir_down(state) ? baddr - ADDR_WIDTH'(1) : baddr + ADDR_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Expected-data pipe: compare happens on the edge after each BIST read
  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      rd_vld   <= 1'b0;
      exp_data <= '0;
      exp_addr <= '0;
    end else begin
      rd_vld   <= run && (op == OP_RD);
      exp_data <= pat;
      exp_addr <= baddr;
    end
  end

  // Fail log: sticky flag, saturating count, address of first miscompare
  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
    end else if (accept) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
    end else if (rd_vld && (a_dout != exp_data)) begin
      fail_q <= 1'b1;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (cnt_q == '0) faddr_q <= exp_addr;
    end
  end

  assign bus.A_DOUT           = a_dout;
  assign bus.A_BIST_BUSY      = busy;
  assign bus.A_BIST_DONE      = done_q;
  assign bus.A_BIST_FAIL      = fail_q;
  assign bus.A_BIST_FAIL_ADDR = faddr_q;
  assign bus.A_BIST_FAIL_CNT  = cnt_q;
endmodule

// File: tb/tb_sram_1p_march_bist.sv
// Self-checking bench for sram_1p_march_bist: functional port, clean and faulty
// March C- runs, counter saturation, reset mid-run and functional traffic mid-run.
module tb_sram_1p_march_bist;
  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int N   = 512;
  localparam int AW2 = 4;
  localparam int N2  = 16;

  logic A_CLK = 1'b0;
  logic A_RESET_N = 1'b0;
  always #5 A_CLK = ~A_CLK;

  sram_1p_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),  .CNT_WIDTH(8)) bus  ();
  sram_1p_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2), .CNT_WIDTH(2)) bus2 ();

  sram_1p_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(8), .BG_CHECKER(1'b0))
    dut (.A_CLK(A_CLK), .A_RESET_N(A_RESET_N), .bus(bus));
  sram_1p_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW2), .CNT_WIDTH(2), .BG_CHECKER(1'b1))
    dut2 (.A_CLK(A_CLK), .A_RESET_N(A_RESET_N), .bus(bus2));

  int tests_run = 0;
  int tests_failed = 0;

  // Stuck-bit masks per address: st1 bits read as 1, st0 bits read as 0
  logic [DW-1:0] st1 [N];
  logic [DW-1:0] st0 [N];
  int stuck_q[$];

  logic [DW-1:0] fm [16];
  logic [DW-1:0] exp_dout;

  // Background word: phase 0 = D0, 1 = D1
  function automatic logic [DW-1:0] bgw(input bit chk, input int ph);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = ((chk && (i % 2 == 0)) ? 1'b1 : 1'b0) ^ ph[0];
    return w;
  endfunction

  // March C- over an n-word array with stuck faults; returns saturated count and first fail addr
  function automatic void march_model(input int n, input bit chk, input int cmax,
                                      output int cnt, output int faddr);
    int rdp[6] = '{-1, 0, 1, 0, 1, 0};
    int wrp[6] = '{ 0, 1, 0, 1, 0, -1};
    logic [DW-1:0] m [];
    m = new[n];
    cnt = 0;
    faddr = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < n; k++) begin
        int a;
        a = (e == 3 || e == 4) ? n - 1 - k : k;
        if (rdp[e] >= 0 && m[a] !== bgw(chk, rdp[e])) begin
          if (cnt == 0) faddr = a;
          if (cnt < cmax) cnt++;
        end
        if (wrp[e] >= 0) m[a] = (bgw(chk, wrp[e]) | st1[a]) & ~st0[a];
      end
    end
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      st1[i] = '0;
      st0[i] = '0;
    end
    stuck_q.delete();
  endtask

  task automatic idle_bus();
    bus.A_MEN = 1'b0; bus.A_WEN = 1'b0; bus.A_REN = 1'b0; bus.A_ADDR = '0;
    bus.A_DIN = '0; bus.A_BM = '0; bus.A_BIST_START = 1'b0;
    bus2.A_MEN = 1'b0; bus2.A_WEN = 1'b0; bus2.A_REN = 1'b0; bus2.A_ADDR = '0;
    bus2.A_DIN = '0; bus2.A_BM = '0; bus2.A_BIST_START = 1'b0;
  endtask

  // Drive one functional op on dut and advance to the next negedge
  task automatic drive(input bit men, input bit wen, input bit ren, input int addr,
                       input logic [DW-1:0] din, input logic [DW-1:0] bm);
    bus.A_MEN = men; bus.A_WEN = wen; bus.A_REN = ren; bus.A_ADDR = AW'(addr);
    bus.A_DIN = din; bus.A_BM = bm;
    @(negedge A_CLK);
    bus.A_MEN = 1'b0; bus.A_WEN = 1'b0; bus.A_REN = 1'b0;
  endtask

  // Pulse START on dut and count cycles with BUSY high. mode 1: hold stuck faults; mode 2: random traffic
  task automatic run_bist(input int mode, output int cycles);
    @(negedge A_CLK);
    bus.A_BIST_START = 1'b1;
    @(negedge A_CLK);
    bus.A_BIST_START = 1'b0;
    cycles = 0;
    while (bus.A_BIST_BUSY === 1'b1 && cycles < 20000) begin
      cycles++;
      if (mode == 1)
        foreach (stuck_q[i])
          dut.u_array.mem[stuck_q[i]] = (dut.u_array.mem[stuck_q[i]] | st1[stuck_q[i]]) & ~st0[stuck_q[i]];
      if (mode == 2) begin
        bus.A_MEN = 1'($urandom); bus.A_WEN = 1'($urandom); bus.A_REN = 1'($urandom);
        bus.A_ADDR = AW'($urandom); bus.A_DIN = $urandom; bus.A_BM = $urandom;
        bus.A_BIST_START = 1'($urandom);
      end
      @(negedge A_CLK);
    end
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    A_RESET_N = 1'b0;
    repeat (3) @(negedge A_CLK);
    for (int pass = 0; pass < 2; pass++) begin
      tests_run++; if (bus.A_BIST_BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.A_BIST_BUSY); end
      tests_run++; if (bus.A_BIST_DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.A_BIST_DONE); end
      tests_run++; if (bus.A_BIST_FAIL !== 1'b0) begin tests_failed++; $display("FAIL reset_fail: got %b want 0", bus.A_BIST_FAIL); end
      tests_run++; if (bus.A_BIST_FAIL_CNT !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", bus.A_BIST_FAIL_CNT); end
      tests_run++; if (bus.A_BIST_FAIL_ADDR !== 9'd0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", bus.A_BIST_FAIL_ADDR); end
      tests_run++; if (bus.A_DOUT !== 32'd0) begin tests_failed++; $display("FAIL reset_dout: got %h want 0", bus.A_DOUT); end
      tests_run++; if (bus2.A_BIST_BUSY !== 1'b0 || bus2.A_BIST_FAIL_CNT !== 2'd0) begin
        tests_failed++; $display("FAIL reset_dut2: busy %b cnt %0d want 0 0", bus2.A_BIST_BUSY, bus2.A_BIST_FAIL_CNT); end
      A_RESET_N = 1'b1;
      @(negedge A_CLK);
    end
  endtask

  task automatic test_functional();
    drive(1, 1, 0, 'h010, 32'hA5A5A5A5, '1);
    drive(1, 1, 0, 'h010, 32'h0, 32'h0000FFFF);
    drive(1, 0, 1, 'h010, 32'h0, 32'h0);
    exp_dout = 32'hA5A50000;
    tests_run++; if (bus.A_DOUT !== exp_dout) begin tests_failed++; $display("FAIL func_masked: got %h want %h", bus.A_DOUT, exp_dout); end
    for (int a = 0; a < 16; a++) begin
      fm[a] = $urandom;
      drive(1, 1, 0, a, fm[a], '1);
    end
    for (int k = 0; k < 300; k++) begin
      bit men, wen, ren;
      int a;
      logic [DW-1:0] din, bm, nw;
      men = 1'($urandom); wen = 1'($urandom); ren = 1'($urandom);
      a = $urandom_range(0, 15); din = $urandom; bm = $urandom;
      drive(men, wen, ren, a, din, bm);
      if (men && wen) begin
        nw = (din & bm) | (fm[a] & ~bm);
        fm[a] = nw;
        if (ren) exp_dout = nw;
      end else if (men && ren) begin
        exp_dout = fm[a];
      end
      tests_run++; if (bus.A_DOUT !== exp_dout) begin
        tests_failed++; $display("FAIL func_random[%0d]: got %h want %h", k, bus.A_DOUT, exp_dout); end
    end
  endtask

  task automatic test_clean_bist();
    int cyc;
    clear_faults();
    run_bist(0, cyc);
    tests_run++; if (cyc != 10 * N + 1) begin tests_failed++; $display("FAIL clean_busy_cycles: got %0d want %0d", cyc, 10 * N + 1); end
    tests_run++; if (bus.A_BIST_DONE !== 1'b1) begin tests_failed++; $display("FAIL clean_done: got %b want 1", bus.A_BIST_DONE); end
    tests_run++; if (bus.A_BIST_FAIL !== 1'b0) begin tests_failed++; $display("FAIL clean_fail: got %b want 0", bus.A_BIST_FAIL); end
    tests_run++; if (bus.A_BIST_FAIL_CNT !== 8'd0) begin tests_failed++; $display("FAIL clean_cnt: got %0d want 0", bus.A_BIST_FAIL_CNT); end
    for (int a = 0; a < N; a++) begin
      drive(1, 0, 1, a, '0, '0);
      tests_run++; if (bus.A_DOUT !== 32'd0) begin tests_failed++; $display("FAIL clean_readback[%0d]: got %h want 0", a, bus.A_DOUT); end
    end
  endtask

  task automatic test_stuck_at();
    int cyc, ecnt, eaddr;
    for (int scen = 0; scen < 3; scen++) begin
      clear_faults();
      if (scen == 0) begin
        st1['h0C3] = 32'h80;
        stuck_q.push_back('h0C3);
      end else begin
        for (int f = 0; f < 2; f++) begin
          int a;
          logic [DW-1:0] msk;
          a = $urandom_range(0, N - 1);
          while (a inside {stuck_q}) a = $urandom_range(0, N - 1);
          msk = 32'h1 << $urandom_range(0, DW - 1);
          if ($urandom_range(0, 1) == 1) st1[a] = msk; else st0[a] = msk;
          stuck_q.push_back(a);
        end
      end
      march_model(N, 1'b0, 255, ecnt, eaddr);
      run_bist(1, cyc);
      tests_run++; if (cyc != 10 * N + 1) begin tests_failed++; $display("FAIL stuck%0d_cycles: got %0d want %0d", scen, cyc, 10 * N + 1); end
      tests_run++; if (bus.A_BIST_FAIL !== (ecnt != 0)) begin tests_failed++; $display("FAIL stuck%0d_flag: got %b want %b", scen, bus.A_BIST_FAIL, ecnt != 0); end
      tests_run++; if (bus.A_BIST_FAIL_CNT !== 8'(ecnt)) begin tests_failed++; $display("FAIL stuck%0d_cnt: got %0d want %0d", scen, bus.A_BIST_FAIL_CNT, ecnt); end
      tests_run++; if (bus.A_BIST_FAIL_ADDR !== 9'(eaddr)) begin tests_failed++; $display("FAIL stuck%0d_addr: got %h want %h", scen, bus.A_BIST_FAIL_ADDR, eaddr); end
      tests_run++; if (bus.A_BIST_DONE !== 1'b1) begin tests_failed++; $display("FAIL stuck%0d_done: got %b want 1", scen, bus.A_BIST_DONE); end
    end
    clear_faults();
  endtask

  task automatic test_saturation();
    int cyc, ecnt, eaddr;
    clear_faults();
    for (int f = 0; f < 3; f++) begin
      int a;
      a = $urandom_range(0, N2 - 1);
      while (a inside {stuck_q}) a = $urandom_range(0, N2 - 1);
      st1[a] = '1;
      stuck_q.push_back(a);
    end
    march_model(N2, 1'b1, 3, ecnt, eaddr);
    @(negedge A_CLK);
    bus2.A_BIST_START = 1'b1;
    @(negedge A_CLK);
    bus2.A_BIST_START = 1'b0;
    cyc = 0;
    while (bus2.A_BIST_BUSY === 1'b1 && cyc < 2000) begin
      cyc++;
      foreach (stuck_q[i]) dut2.u_array.mem[stuck_q[i]] = '1;
      @(negedge A_CLK);
    end
    tests_run++; if (cyc != 10 * N2 + 1) begin tests_failed++; $display("FAIL sat_cycles: got %0d want %0d", cyc, 10 * N2 + 1); end
    tests_run++; if (bus2.A_BIST_FAIL_CNT !== 2'(ecnt)) begin tests_failed++; $display("FAIL sat_cnt: got %0d want %0d", bus2.A_BIST_FAIL_CNT, ecnt); end
    tests_run++; if (bus2.A_BIST_FAIL_ADDR !== 4'(eaddr)) begin tests_failed++; $display("FAIL sat_addr: got %h want %h", bus2.A_BIST_FAIL_ADDR, eaddr); end
    tests_run++; if (bus2.A_BIST_FAIL !== 1'b1) begin tests_failed++; $display("FAIL sat_flag: got %b want 1", bus2.A_BIST_FAIL); end
    clear_faults();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    @(negedge A_CLK);
    bus.A_BIST_START = 1'b1;
    @(negedge A_CLK);
    bus.A_BIST_START = 1'b0;
    repeat (999) @(negedge A_CLK);
    tests_run++; if (bus.A_BIST_BUSY !== 1'b1 || bus.A_BIST_DONE !== 1'b0) begin
      tests_failed++; $display("FAIL midrun_state: busy %b done %b want 1 0", bus.A_BIST_BUSY, bus.A_BIST_DONE); end
    #2 A_RESET_N = 1'b0;
    #1;
    tests_run++; if (bus.A_BIST_BUSY !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b want 0", bus.A_BIST_BUSY); end
    tests_run++; if (bus.A_BIST_DONE !== 1'b0 || bus.A_BIST_FAIL !== 1'b0) begin
      tests_failed++; $display("FAIL abort_status: done %b fail %b want 0 0", bus.A_BIST_DONE, bus.A_BIST_FAIL); end
    tests_run++; if (bus.A_BIST_FAIL_CNT !== 8'd0) begin tests_failed++; $display("FAIL abort_cnt: got %0d want 0", bus.A_BIST_FAIL_CNT); end
    @(negedge A_CLK);
    A_RESET_N = 1'b1;
    run_bist(0, cyc);
    tests_run++; if (cyc != 10 * N + 1) begin tests_failed++; $display("FAIL rerun_cycles: got %0d want %0d", cyc, 10 * N + 1); end
    tests_run++; if (bus.A_BIST_DONE !== 1'b1 || bus.A_BIST_FAIL !== 1'b0) begin
      tests_failed++; $display("FAIL rerun_status: done %b fail %b want 1 0", bus.A_BIST_DONE, bus.A_BIST_FAIL); end
  endtask

  task automatic test_ignored_midrun();
    int cyc;
    logic [DW-1:0] d;
    run_bist(2, cyc);
    tests_run++; if (cyc != 10 * N + 1) begin tests_failed++; $display("FAIL noise_cycles: got %0d want %0d", cyc, 10 * N + 1); end
    tests_run++; if (bus.A_BIST_DONE !== 1'b1) begin tests_failed++; $display("FAIL noise_done: got %b want 1", bus.A_BIST_DONE); end
    tests_run++; if (bus.A_BIST_FAIL !== 1'b0 || bus.A_BIST_FAIL_CNT !== 8'd0) begin
      tests_failed++; $display("FAIL noise_fail: flag %b cnt %0d want 0 0", bus.A_BIST_FAIL, bus.A_BIST_FAIL_CNT); end
    for (int a = 0; a < N; a++) begin
      drive(1, 0, 1, a, '0, '0);
      tests_run++; if (bus.A_DOUT !== 32'd0) begin tests_failed++; $display("FAIL noise_readback[%0d]: got %h want 0", a, bus.A_DOUT); end
    end
    d = $urandom;
    drive(1, 1, 0, 'h1AB, d, '1);
    drive(1, 0, 1, 'h1AB, '0, '0);
    tests_run++; if (bus.A_DOUT !== d) begin tests_failed++; $display("FAIL post_done_rw: got %h want %h", bus.A_DOUT, d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_faults();
    test_reset();
    test_functional();
    test_clean_bist();
    test_stuck_at();
    test_saturation();
    test_reset_mid_run();
    test_ignored_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
